// File: rtl/sm4_key_sched_iter_pkg.sv
// SM4 key-schedule shared definitions: FK constants, S-box, CK generator,
// rotate helper and the scheduler FSM state type.
package sm4_pkg;

  localparam logic [31:0]  FK0 = 32'ha3b1bac6;
  localparam logic [31:0]  FK1 = 32'h56aa3350;
  localparam logic [31:0]  FK2 = 32'h677d9197;
  localparam logic [31:0]  FK3 = 32'hb27022dc;
  localparam logic [127:0] FK  = {FK0, FK1, FK2, FK3};

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  localparam logic [7:0] SBOX_TBL [256] = '{
    8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
    8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
    8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
    8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
    8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
    8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
    8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
    8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
    8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
    8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
    8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
    8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
    8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
    8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
    8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
    8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[x];
  endfunction

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // CK(i) byte j = (4i+j)*7 mod 256, byte 0 in the MSB; 8-bit math gives the mod for free.
  function automatic logic [31:0] ck_gen(input logic [4:0] i);
    logic [31:0] ck;
    logic [7:0]  b;
    ck = '0;
    for (int j = 0; j < 4; j++) begin
      b = ({1'b0, i, 2'b00} + 8'(j)) * 8'd7;
      ck[31-8*j -: 8] = b;
    end
    return ck;
  endfunction

endpackage

// File: rtl/sm4_key_round.sv
// One SM4 key-expansion round: window {K(i)..K(i+3)} + CK(i) -> {K(i+1)..K(i+4)}, rk = K(i+4).
module sm4_key_round
  import sm4_pkg::*;
(
  input  logic [127:0] win_in,
  input  logic [31:0]  ck_in,
  output logic [127:0] win_out,
  output logic [31:0]  rk_out
);

  logic [31:0] k0, k1, k2, k3, x, b, t;

  always_comb begin
    {k0, k1, k2, k3} = win_in;
    x = k1 ^ k2 ^ k3 ^ ck_in;
    b = '0;
    for (int j = 0; j < 4; j++) b[8*j +: 8] = sbox(x[8*j +: 8]);
    t = b ^ rotl32(b, 13) ^ rotl32(b, 23);
    rk_out  = k0 ^ t;
    win_out = {k1, k2, k3, rk_out};
  end

endmodule

// File: rtl/sm4_key_sched_iter.sv
// Iterated SM4 key schedule, RPC rounds per clock, streamed with valid/index strobe.
// Optional SM4_KEY_STORE_EN adds a 32x32 round-key store with a combinational read port.
module sm4_key_sched_iter
  import sm4_pkg::*;
#(
  parameter int RPC        = 1,
  parameter int NUM_ROUNDS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_in,
  input  logic [127:0]      key_in,
  output logic              busy_out,
  output logic              rk_valid_out,
  output logic [4:0]        rk_idx_out,
  output logic [32*RPC-1:0] rk_out,
  output logic              done_out
`ifdef SM4_KEY_STORE_EN
  ,
  input  logic [4:0]        rk_rd_addr_in,
  output logic [31:0]       rk_rd_data_out,
  output logic              keys_ready_out
`endif
);

  if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8)) begin : g_bad_rpc
    $error("sm4_key_sched_iter: RPC must be 1, 2, 4 or 8");
  end
  if ((NUM_ROUNDS % RPC) != 0 || NUM_ROUNDS > 32 || NUM_ROUNDS < RPC) begin : g_bad_rounds
    $error("sm4_key_sched_iter: NUM_ROUNDS must be a multiple of RPC and at most 32");
  end

  state_e              state_q, state_d;
  logic [4:0]          r_q, r_d;
  logic [127:0]        win_q, win_d;
  logic [32*RPC-1:0]   rk_q, rk_d;

  logic                accept, last_grp;
  logic [5:0]          next_base;
  logic [4:0]          base;
  logic [RPC:0][127:0] chain_win;
  logic [RPC-1:0][31:0] chain_rk;
  logic [RPC-1:0][31:0] chain_ck;

  // r_q is the index of the group currently on rk_out; the chain computes the next group.
  assign accept    = (state_q == ST_IDLE) && start_in;
  assign next_base = {1'b0, r_q} + 6'(RPC);
  assign last_grp  = (next_base == 6'(NUM_ROUNDS));
  assign base      = (state_q == ST_IDLE) ? 5'd0 : next_base[4:0];
  assign chain_win[0] = (state_q == ST_IDLE) ? (key_in ^ FK) : win_q;

  for (genvar j = 0; j < RPC; j++) begin : g_round
    assign chain_ck[j] = ck_gen(base + 5'(j));
    sm4_key_round u_round (
      .win_in  (chain_win[j]),
      .ck_in   (chain_ck[j]),
      .win_out (chain_win[j+1]),
      .rk_out  (chain_rk[j])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_in) state_d = ST_RUN;
      ST_RUN:  if (last_grp) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_out     = (state_q == ST_RUN);
    rk_valid_out = (state_q == ST_RUN);
    done_out     = (state_q == ST_DONE);
    rk_idx_out   = r_q;
    rk_out       = rk_q;
  end

  always_comb begin
    win_d = win_q;
    rk_d  = rk_q;
    r_d   = r_q;
    if (accept) begin
      win_d = chain_win[RPC];
      rk_d  = chain_rk;
      r_d   = '0;
    end else if (state_q == ST_RUN && !last_grp) begin
      win_d = chain_win[RPC];
      rk_d  = chain_rk;
      r_d   = next_base[4:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '0;
      rk_q  <= '0;
      r_q   <= '0;
    end else begin
      win_q <= win_d;
      rk_q  <= rk_d;
      r_q   <= r_d;
    end
  end

`ifdef SM4_KEY_STORE_EN
  logic [31:0] key_mem_q [32];
  logic        keys_ready_q, keys_ready_d;

  always_ff @(posedge clk) begin
    if (rk_valid_out) begin
      for (int j = 0; j < RPC; j++) key_mem_q[r_q + 5'(j)] <= rk_q[32*j +: 32];
    end
  end

  always_comb begin
    keys_ready_d = keys_ready_q;
    if (accept)                    keys_ready_d = 1'b0;
    else if (state_q == ST_DONE)   keys_ready_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) keys_ready_q <= 1'b0;
    else        keys_ready_q <= keys_ready_d;
  end

  assign rk_rd_data_out = key_mem_q[rk_rd_addr_in];
  assign keys_ready_out = keys_ready_q;
`endif

endmodule

// File: tb/tb_sm4_key_sched_iter.sv
// Bench for sm4_key_sched_iter: RPC=1 and RPC=4 instances against an array-based SM4 key model.
module tb_sm4_key_sched_iter;

  localparam logic [127:0] KV = 128'h0123456789abcdeffedcba9876543210;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start1 = 1'b0, start4 = 1'b0;
  logic [127:0] key1 = '0, key4 = '0;
  logic         busy1, vld1, done1, busy4, vld4, done4;
  logic [4:0]   idx1, idx4;
  logic [31:0]  rk1;
  logic [127:0] rk4;
`ifdef SM4_KEY_STORE_EN
  logic [4:0]   rd_addr1 = '0, rd_addr4 = '0;
  logic [31:0]  rd_data1, rd_data4;
  logic         kr1, kr4;
`endif

  always #5 clk = ~clk;

  sm4_key_sched_iter #(.RPC(1), .NUM_ROUNDS(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_in(start1), .key_in(key1),
    .busy_out(busy1), .rk_valid_out(vld1), .rk_idx_out(idx1), .rk_out(rk1), .done_out(done1)
`ifdef SM4_KEY_STORE_EN
    , .rk_rd_addr_in(rd_addr1), .rk_rd_data_out(rd_data1), .keys_ready_out(kr1)
`endif
  );

  sm4_key_sched_iter #(.RPC(4), .NUM_ROUNDS(32)) dut4 (
    .clk(clk), .rst_n(rst_n), .start_in(start4), .key_in(key4),
    .busy_out(busy4), .rk_valid_out(vld4), .rk_idx_out(idx4), .rk_out(rk4), .done_out(done4)
`ifdef SM4_KEY_STORE_EN
    , .rk_rd_addr_in(rd_addr4), .rk_rd_data_out(rd_data4), .keys_ready_out(kr4)
`endif
  );

  int checks = 0, errors = 0;

  logic [7:0] SB [256] = '{
    8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
    8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
    8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
    8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
    8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
    8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
    8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
    8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
    8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
    8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
    8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
    8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
    8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
    8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
    8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
    8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
  };
  logic [31:0] FKM [4] = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};

  logic [31:0] exp_rk [32];
  logic [31:0] cap1 [32];
  logic [31:0] cap4 [32];
  int nv1, nv4, bad_idx1, bad_idx4, ndone1, ndone4, first_v1, last_v1, done_at1, busy_bad;

  function automatic logic [31:0] m_rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Reference schedule: plain K[0..35] array straight from the round definition.
  task automatic ref_sched(input logic [127:0] mk);
    logic [31:0] k [36];
    logic [31:0] x, t, ck;
    for (int i = 0; i < 4; i++) k[i] = mk[127-32*i -: 32] ^ FKM[i];
    for (int i = 0; i < 32; i++) begin
      ck = '0;
      for (int j = 0; j < 4; j++) ck = (ck << 8) | 32'(((4*i + j) * 7) % 256);
      x = k[i+1] ^ k[i+2] ^ k[i+3] ^ ck;
      t = {SB[x[31:24]], SB[x[23:16]], SB[x[15:8]], SB[x[7:0]]};
      t = t ^ m_rotl(t, 13) ^ m_rotl(t, 23);
      k[i+4] = k[i] ^ t;
      exp_rk[i] = k[i+4];
    end
  endtask

  task automatic do_start(input logic [127:0] k);
    key1 = k; key4 = k; start1 = 1'b1; start4 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start4 = 1'b0;
  endtask

  // Records 40 cycles of both instances starting with the cycle after start.
  task automatic capture(input bit pulse5, input bit pulse_done);
    nv1 = 0; nv4 = 0; bad_idx1 = 0; bad_idx4 = 0; ndone1 = 0; ndone4 = 0;
    first_v1 = -1; last_v1 = -1; done_at1 = -1; busy_bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (vld1 === 1'b1) begin
        if (first_v1 < 0) first_v1 = i;
        last_v1 = i;
        if (idx1 !== 5'(nv1)) bad_idx1++;
        if (nv1 < 32) cap1[nv1] = rk1;
        nv1++;
      end
      if (vld4 === 1'b1) begin
        if (idx4 !== 5'(4*nv4)) bad_idx4++;
        if (nv4 < 8) for (int j = 0; j < 4; j++) cap4[4*nv4+j] = rk4[32*j +: 32];
        nv4++;
      end
      if (busy1 !== vld1) busy_bad++;
      if (done1 === 1'b1) begin ndone1++; done_at1 = i; end
      if (done4 === 1'b1) ndone4++;
      start1 = (pulse5 && i == 4) || (pulse_done && done1 === 1'b1);
      key1 = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    start1 = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy1, vld1, idx1, rk1, done1} !== '0) begin
      errors++; $display("FAIL reset_rpc1 got %h exp 0", {busy1, vld1, idx1, rk1, done1});
    end
    checks++;
    if ({busy4, vld4, idx4, rk4, done4} !== '0) begin
      errors++; $display("FAIL reset_rpc4 got %h exp 0", {busy4, vld4, idx4, rk4, done4});
    end
`ifdef SM4_KEY_STORE_EN
    checks++;
    if (kr1 !== 1'b0) begin errors++; $display("FAIL reset_keys_ready got %b exp 0", kr1); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_vector;
    ref_sched(KV);
    do_start(KV);
    capture(1'b0, 1'b0);
    checks++;
    if (first_v1 !== 0) begin errors++; $display("FAIL first_valid_cycle got %0d exp 0", first_v1); end
    checks++;
    if (cap1[0] !== 32'hf12186f9) begin errors++; $display("FAIL rk0 got %h exp f12186f9", cap1[0]); end
    checks++;
    if (cap1[31] !== 32'h9124a012) begin errors++; $display("FAIL rk31 got %h exp 9124a012", cap1[31]); end
    checks++;
    if (nv1 !== 32 || bad_idx1 !== 0 || last_v1 !== 31) begin
      errors++; $display("FAIL rpc1_stream got n=%0d badidx=%0d last=%0d exp 32/0/31", nv1, bad_idx1, last_v1);
    end
    checks++;
    if (ndone1 !== 1 || done_at1 !== 32) begin
      errors++; $display("FAIL rpc1_done got n=%0d at=%0d exp 1 at 32", ndone1, done_at1);
    end
    checks++;
    if (busy_bad !== 0) begin errors++; $display("FAIL busy_vs_valid got %0d bad cycles exp 0", busy_bad); end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (cap1[i] !== exp_rk[i]) begin errors++; $display("FAIL vec_rk%0d got %h exp %h", i, cap1[i], exp_rk[i]); end
    end
    checks++;
    if (rk1 !== exp_rk[31] || vld1 !== 1'b0) begin
      errors++; $display("FAIL rk_hold got %h/%b exp %h/0", rk1, vld1, exp_rk[31]);
    end
`ifdef SM4_KEY_STORE_EN
    rd_addr1 = 5'd31; rd_addr4 = 5'd31; #1;
    checks++;
    if (rd_data1 !== 32'h9124a012) begin errors++; $display("FAIL store_rd31 got %h exp 9124a012", rd_data1); end
    checks++;
    if (rd_data4 !== 32'h9124a012) begin errors++; $display("FAIL store4_rd31 got %h exp 9124a012", rd_data4); end
    rd_addr1 = 5'd0; #1;
    checks++;
    if (rd_data1 !== 32'hf12186f9) begin errors++; $display("FAIL store_rd0 got %h exp f12186f9", rd_data1); end
    checks++;
    if (kr1 !== 1'b1) begin errors++; $display("FAIL keys_ready_set got %b exp 1", kr1); end
`endif
  endtask

  task automatic test_rpc4;
    checks++;
    if (nv4 !== 8 || bad_idx4 !== 0 || ndone4 !== 1) begin
      errors++; $display("FAIL rpc4_stream got n=%0d badidx=%0d done=%0d exp 8/0/1", nv4, bad_idx4, ndone4);
    end
    checks++;
    if (cap4[0] !== 32'hf12186f9) begin errors++; $display("FAIL rpc4_rk0 got %h exp f12186f9", cap4[0]); end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (cap4[i] !== exp_rk[i]) begin errors++; $display("FAIL rpc4_rk%0d got %h exp %h", i, cap4[i], exp_rk[i]); end
    end
  endtask

  task automatic test_ignore_start;
    ref_sched(KV);
    do_start(KV);
`ifdef SM4_KEY_STORE_EN
    checks++;
    if (kr1 !== 1'b0) begin errors++; $display("FAIL keys_ready_clear got %b exp 0", kr1); end
`endif
    capture(1'b1, 1'b1);
    checks++;
    if (nv1 !== 32 || ndone1 !== 1 || done_at1 !== 32) begin
      errors++; $display("FAIL ignore_start got n=%0d done=%0d at=%0d exp 32/1/32", nv1, ndone1, done_at1);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (cap1[i] !== exp_rk[i]) begin errors++; $display("FAIL ign_rk%0d got %h exp %h", i, cap1[i], exp_rk[i]); end
    end
  endtask

  task automatic test_reset_mid;
    int cnt;
    cnt = 0;
    do_start(KV);
    for (int i = 0; i < 50 && cnt < 10; i++) begin
      if (vld1 === 1'b1) cnt++;
      if (cnt < 10) @(negedge clk);
    end
    checks++;
    if (cnt !== 10) begin errors++; $display("FAIL reset_mid_timeout got %0d valids exp 10", cnt); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy1, vld1, idx1, rk1, done1} !== '0) begin
      errors++; $display("FAIL reset_mid_rpc1 got %h exp 0", {busy1, vld1, idx1, rk1, done1});
    end
    checks++;
    if ({busy4, vld4, idx4, rk4, done4} !== '0) begin
      errors++; $display("FAIL reset_mid_rpc4 got %h exp 0", {busy4, vld4, idx4, rk4, done4});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (vld1 !== 1'b0 || busy1 !== 1'b0) begin
      errors++; $display("FAIL reset_no_resume got vld=%b busy=%b exp 0/0", vld1, busy1);
    end
    ref_sched('0);
    do_start('0);
    capture(1'b0, 1'b0);
    checks++;
    if (nv1 !== 32) begin errors++; $display("FAIL zero_key_count got %0d exp 32", nv1); end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (cap1[i] !== exp_rk[i]) begin errors++; $display("FAIL zero_rk%0d got %h exp %h", i, cap1[i], exp_rk[i]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [127:0] k;
    for (int s = 0; s < 2; s++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      ref_sched(k);
      do_start(k);
      capture(1'b0, 1'b0);
      for (int i = 0; i < 32; i++) begin
        checks++;
        if (cap1[i] !== exp_rk[i] || cap4[i] !== exp_rk[i]) begin
          errors++; $display("FAIL b2b%0d_rk%0d got %h/%h exp %h", s, i, cap1[i], cap4[i], exp_rk[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_vector();
    test_rpc4();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
